// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the sample-SRAM port arbiter and its picker.
package sram_port_arbiter_pkg;

    localparam int AW_DEF     = 12;
    localparam int DW_DEF     = 16;
    localparam int SRAM_DEPTH = 4096;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    // Successor of a requester id, wrapping at nreq.
    function automatic req_id_t wrap_inc(input req_id_t id, input int unsigned nreq);
        wrap_inc = ((32'(id) + 32'd1) >= nreq) ? 2'd0 : (id + 2'd1);
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: packed request lanes plus read response.
interface sram_port_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 12,
    parameter int DW   = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_port_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_arb_pick
    import sram_port_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] valid,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] gnt,
    output req_id_t         id
);
    logic       found_s;
    logic [1:0] idx_s;

    // Scan NREQ slots starting at ptr and keep the first valid one.
    always_comb begin
        gnt     = '0;
        id      = 2'd0;
        found_s = 1'b0;
        idx_s   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = 2'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (!found_s && valid[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                id         = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with optional burst lock sharing one sync SRAM between NREQ requesters.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int RSP_REG  = 1,
    parameter int LOCK_MAX = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.slave   bus,
    output req_id_t              grant_id,
    output logic                 locked,
    output logic                 mem_cs,
    output logic                 mem_web,
    output logic [AW-1:0]        mem_a,
    output logic [DW-1:0]        mem_di,
    output logic                 mem_oe,
    input  logic [DW-1:0]        mem_do
);
    arb_state_t      state_r, state_s;
    req_id_t         owner_r, owner_s;
    req_id_t         rr_ptr_r, rr_ptr_s;
    logic [15:0]     lock_cnt_r, lock_cnt_s;

    logic [NREQ-1:0] pick_gnt_s;
    req_id_t         pick_id_s;
    logic [NREQ-1:0] ready_s;
    req_id_t         acc_id_s;
    int              acc_idx_s;
    logic            accept_s;
    logic            acc_we_s;
    logic [AW-1:0]   acc_addr_s;
    logic [DW-1:0]   acc_wdata_s;

    logic            v1_r, v2_r, v3_r;
    req_id_t         id1_r, id2_r, id3_r;
    logic [DW-1:0]   rsp_data_r;
    logic            rsp_v_s;
    req_id_t         rsp_id_s;
    logic [DW-1:0]   rsp_d_s;

    rr_arb_pick #(.NREQ(NREQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_r),
        .gnt   (pick_gnt_s),
        .id    (pick_id_s)
    );

    // Grant vector: picker in ARB, owner only while locked, nothing during reset.
    always_comb begin
        ready_s  = '0;
        acc_id_s = pick_id_s;
        if (!rst_n) begin
            ready_s = '0;
        end else if (state_r == LOCKED) begin
            ready_s[owner_r] = bus.req_valid[owner_r];
            acc_id_s         = owner_r;
        end else begin
            ready_s = pick_gnt_s;
        end
    end

    assign accept_s    = |(ready_s & bus.req_valid);
    assign acc_idx_s   = int'(acc_id_s);
    assign acc_we_s    = bus.req_we[acc_id_s];
    assign acc_addr_s  = bus.req_addr[acc_idx_s*AW +: AW];
    assign acc_wdata_s = bus.req_wdata[acc_idx_s*DW +: DW];

    // Arbitration FSM: lock entry on a locked beat, three release conditions.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        lock_cnt_s = lock_cnt_r;
        case (state_r)
            ARB: begin
                if (accept_s) begin
                    rr_ptr_s = wrap_inc(acc_id_s, NREQ);
                    if (bus.req_lock[acc_id_s]) begin
                        state_s    = LOCKED;
                        owner_s    = acc_id_s;
                        lock_cnt_s = 16'd0;
                    end else begin
                        state_s = ARB;
                    end
                end else begin
                    state_s = ARB;
                end
            end
            LOCKED: begin
                lock_cnt_s = lock_cnt_r + 16'd1;
                if ((bus.req_valid[owner_r] && !bus.req_lock[owner_r]) ||
                    (!bus.req_valid[owner_r] && !bus.req_lock[owner_r]) ||
                    ((LOCK_MAX != 0) && (lock_cnt_r == 16'(LOCK_MAX - 1)))) begin
                    state_s  = ARB;
                    rr_ptr_s = wrap_inc(owner_r, NREQ);
                end else begin
                    state_s = LOCKED;
                end
            end
            default: state_s = ARB;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ARB;
            owner_r    <= 2'd0;
            rr_ptr_r   <= 2'd0;
            lock_cnt_r <= 16'd0;
            grant_id   <= 2'd0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            lock_cnt_r <= lock_cnt_s;
            if (accept_s) grant_id <= acc_id_s;
        end
    end

    // SRAM pin stage; address and data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_cs  <= 1'b0;
            mem_web <= 1'b1;
            mem_a   <= '0;
            mem_di  <= '0;
        end else begin
            mem_cs  <= accept_s;
            mem_web <= accept_s ? ~acc_we_s : 1'b1;
            if (accept_s) begin
                mem_a  <= acc_addr_s;
                mem_di <= acc_wdata_s;
            end
        end
    end

    // Read id pipe follows the SRAM latency; optional output data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            v3_r       <= 1'b0;
            id1_r      <= 2'd0;
            id2_r      <= 2'd0;
            id3_r      <= 2'd0;
            rsp_data_r <= '0;
        end else begin
            v1_r  <= accept_s & ~acc_we_s;
            id1_r <= acc_id_s;
            v2_r  <= v1_r;
            id2_r <= id1_r;
            v3_r  <= v2_r;
            id3_r <= id2_r;
            if (v2_r) rsp_data_r <= mem_do;
        end
    end

    if (RSP_REG != 0) begin : g_rsp_reg
        assign rsp_v_s  = v3_r;
        assign rsp_id_s = id3_r;
        assign rsp_d_s  = rsp_data_r;
    end else begin : g_rsp_comb
        assign rsp_v_s  = v2_r;
        assign rsp_id_s = id2_r;
        assign rsp_d_s  = v2_r ? mem_do : '0;
    end

    // Steer the response pulse to the issuing requester.
    always_comb begin
        bus.rsp_valid = '0;
        if (rsp_v_s) begin
            bus.rsp_valid[rsp_id_s] = 1'b1;
        end else begin
            bus.rsp_valid = '0;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_data  = rsp_d_s;
    assign locked        = (state_r == LOCKED);
    assign mem_oe        = 1'b1;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: unlimited-lock instance on a sync SRAM model plus a LOCK_MAX=8 instance.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.NREQ(3), .AW(12), .DW(16)) bus0 ();
    sram_port_arbiter_if #(.NREQ(3), .AW(12), .DW(16)) bus1 ();

    req_id_t     grant_id0, grant_id1;
    logic        locked0, mem_cs0, mem_web0, mem_oe0;
    logic        locked1, mem_cs1, mem_web1, mem_oe1;
    logic [11:0] mem_a0, mem_a1;
    logic [15:0] mem_di0, mem_di1, mem_do0;
    logic [15:0] mem_do1 = 16'h0000;
    logic [15:0] sram [0:4095];

    sram_port_arbiter #(.NREQ(3), .AW(12), .DW(16), .RSP_REG(1), .LOCK_MAX(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .grant_id(grant_id0), .locked(locked0),
        .mem_cs(mem_cs0), .mem_web(mem_web0), .mem_a(mem_a0), .mem_di(mem_di0),
        .mem_oe(mem_oe0), .mem_do(mem_do0)
    );

    sram_port_arbiter #(.NREQ(3), .AW(12), .DW(16), .RSP_REG(1), .LOCK_MAX(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .grant_id(grant_id1), .locked(locked1),
        .mem_cs(mem_cs1), .mem_web(mem_web1), .mem_a(mem_a1), .mem_di(mem_di1),
        .mem_oe(mem_oe1), .mem_do(mem_do1)
    );

    // Synchronous single-port SRAM: read data appears the cycle after the address is sampled.
    always @(posedge clk) begin
        if (mem_cs0) begin
            if (!mem_web0) sram[mem_a0] <= mem_di0;
            else           mem_do0 <= sram[mem_a0];
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input int i, input logic v, input logic we, input logic lk,
                        input logic [11:0] a, input logic [15:0] d);
        bus0.req_valid[i]          = v;
        bus0.req_we[i]             = we;
        bus0.req_lock[i]           = lk;
        bus0.req_addr[i*12 +: 12]  = a;
        bus0.req_wdata[i*16 +: 16] = d;
    endtask

    task automatic drv1(input int i, input logic v, input logic we, input logic lk,
                        input logic [11:0] a, input logic [15:0] d);
        bus1.req_valid[i]          = v;
        bus1.req_we[i]             = we;
        bus1.req_lock[i]           = lk;
        bus1.req_addr[i*12 +: 12]  = a;
        bus1.req_wdata[i*16 +: 16] = d;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            drv0(i, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
            drv1(i, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus0.req_valid = 3'b111;
        bus1.req_valid = 3'b111;
        next();
        next();
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready0 got=%b exp=000", bus0.req_ready);
        end
        n_checks++;
        if (bus1.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready1 got=%b exp=000", bus1.req_ready);
        end
        n_checks++;
        if ({mem_cs0, mem_web0} !== 2'b01) begin
            n_fail++; $display("FAIL reset_mem_cs_web got=%b exp=01", {mem_cs0, mem_web0});
        end
        n_checks++;
        if (bus0.rsp_valid !== 3'b000) begin
            n_fail++; $display("FAIL reset_rsp_valid got=%b exp=000", bus0.rsp_valid);
        end
        n_checks++;
        if ({locked0, grant_id0, mem_a0, mem_di0, bus0.rsp_data} !== 47'd0) begin
            n_fail++; $display("FAIL reset_regs got=%b/%0d/%h/%h/%h exp=0",
                               locked0, grant_id0, mem_a0, mem_di0, bus0.rsp_data);
        end
        next();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [11:0] ad [3];
        logic [15:0] wd [3];
        logic [2:0]  exp3;
        ad[0] = 12'h010; ad[1] = 12'h020; ad[2] = 12'h030;
        wd[0] = 16'hA010; wd[1] = 16'hB020; wd[2] = 16'hC030;
        for (int i = 0; i < 3; i++) drv0(i, 1'b1, 1'b1, 1'b0, ad[i], wd[i]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp3 = 3'b001 << c;
            n_checks++;
            if (bus0.req_ready !== exp3) begin
                n_fail++; $display("FAIL rr_write_ready c=%0d got=%b exp=%b", c, bus0.req_ready, exp3);
            end
            if (c == 1) begin
                n_checks++;
                if ({mem_cs0, mem_web0, mem_a0, mem_di0} !== {1'b1, 1'b0, 12'h010, 16'hA010}) begin
                    n_fail++; $display("FAIL rr_mem_pins got=%b%b %h %h exp=10 010 a010",
                                       mem_cs0, mem_web0, mem_a0, mem_di0);
                end
            end
            next();
            bus0.req_valid[c] = 1'b0;
        end
        for (int i = 0; i < 3; i++) drv0(i, 1'b0, 1'b0, 1'b0, ad[i], 16'h0000);
        for (int c = 0; c < 9; c++) begin
            bus0.req_valid = (c < 6) ? 3'b111 : 3'b000;
            @(negedge clk);
            exp3 = (c < 6) ? (3'b001 << (c % 3)) : 3'b000;
            n_checks++;
            if (bus0.req_ready !== exp3) begin
                n_fail++; $display("FAIL rr_read_ready c=%0d got=%b exp=%b", c, bus0.req_ready, exp3);
            end
            exp3 = (c >= 3) ? (3'b001 << ((c - 3) % 3)) : 3'b000;
            n_checks++;
            if (bus0.rsp_valid !== exp3) begin
                n_fail++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, bus0.rsp_valid, exp3);
            end
            if (c >= 3) begin
                n_checks++;
                if (bus0.rsp_data !== wd[(c - 3) % 3]) begin
                    n_fail++; $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, bus0.rsp_data, wd[(c - 3) % 3]);
                end
            end
            if (c >= 1 && c <= 6) begin
                n_checks++;
                if (grant_id0 !== req_id_t'((c - 1) % 3)) begin
                    n_fail++; $display("FAIL rr_grant_id c=%0d got=%0d exp=%0d", c, grant_id0, (c - 1) % 3);
                end
            end
            next();
        end
    endtask

    task automatic test_lock_burst();
        int          ok_cnt;
        logic [11:0] aa;
        ok_cnt = 0;
        drv0(1, 1'b1, 1'b0, 1'b0, 12'hABC, 16'h0000);
        for (int a = 0; a < 4096; a++) begin
            aa = 12'(a);
            drv0(0, 1'b1, 1'b1, (a != 4095), aa, {aa[3:0], aa});
            @(negedge clk);
            if (bus0.req_ready === 3'b001) ok_cnt++;
            if (a == 100) begin
                n_checks++;
                if (locked0 !== 1'b1) begin
                    n_fail++; $display("FAIL lock_held got=%b exp=1", locked0);
                end
            end
            next();
        end
        drv0(0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
        n_checks++;
        if (ok_cnt !== 4096) begin
            n_fail++; $display("FAIL lock_owner_cycles got=%0d exp=4096", ok_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({bus0.req_ready, locked0} !== {3'b010, 1'b0}) begin
            n_fail++; $display("FAIL lock_release_grant got=%b/%b exp=010/0", bus0.req_ready, locked0);
        end
        next();
        bus0.req_valid[1] = 1'b0;
        @(negedge clk); next();
        @(negedge clk); next();
        @(negedge clk);
        n_checks++;
        if ({bus0.rsp_valid, bus0.rsp_data} !== {3'b010, 16'hCABC}) begin
            n_fail++; $display("FAIL lock_readback got=%b/%h exp=010/cabc", bus0.rsp_valid, bus0.rsp_data);
        end
        next();
    endtask

    task automatic test_write_then_read();
        drv0(1, 1'b1, 1'b1, 1'b0, 12'h7FF, 16'h1234);
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 3'b010) begin
            n_fail++; $display("FAIL wtr_write_ready got=%b exp=010", bus0.req_ready);
        end
        next();
        drv0(1, 1'b1, 1'b0, 1'b0, 12'h7FF, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 3'b010) begin
            n_fail++; $display("FAIL wtr_read_ready got=%b exp=010", bus0.req_ready);
        end
        next();
        bus0.req_valid = 3'b000;
        for (int c = 2; c < 6; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_checks++;
                if ({bus0.rsp_valid, bus0.rsp_data} !== {3'b010, 16'h1234}) begin
                    n_fail++; $display("FAIL wtr_rsp got=%b/%h exp=010/1234", bus0.rsp_valid, bus0.rsp_data);
                end
            end else if (c != 2) begin
                n_checks++;
                if (bus0.rsp_valid !== 3'b000) begin
                    n_fail++; $display("FAIL wtr_single_pulse c=%0d got=%b exp=000", c, bus0.rsp_valid);
                end
            end
            next();
        end
    endtask

    task automatic test_watchdog();
        logic [2:0] exp3;
        logic       exp_lk;
        drv1(0, 1'b1, 1'b0, 1'b1, 12'h000, 16'h0000);
        drv1(2, 1'b1, 1'b0, 1'b0, 12'h005, 16'h0000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp3   = (c <= 8) ? 3'b001 : 3'b100;
            exp_lk = (c >= 1 && c <= 8);
            n_checks++;
            if (bus1.req_ready !== exp3) begin
                n_fail++; $display("FAIL wd_ready c=%0d got=%b exp=%b", c, bus1.req_ready, exp3);
            end
            n_checks++;
            if (locked1 !== exp_lk) begin
                n_fail++; $display("FAIL wd_locked c=%0d got=%b exp=%b", c, locked1, exp_lk);
            end
            next();
        end
        for (int i = 0; i < 3; i++) drv1(i, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    endtask

    task automatic test_mid_read_reset();
        drv0(1, 1'b1, 1'b0, 1'b0, 12'h7FF, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 3'b010) begin
            n_fail++; $display("FAIL mrr_accept got=%b exp=010", bus0.req_ready);
        end
        next();
        rst_n = 1'b0;
        drv0(0, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000);
        drv0(2, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000);
        @(negedge clk);
        n_checks++;
        if (bus0.req_ready !== 3'b000) begin
            n_fail++; $display("FAIL mrr_ready_in_reset got=%b exp=000", bus0.req_ready);
        end
        next();
        @(negedge clk);
        n_checks++;
        if ({bus0.req_ready, bus0.rsp_valid, mem_cs0, mem_web0} !== {3'b000, 3'b000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mrr_reset_state got=%b/%b/%b%b exp=000/000/01",
                               bus0.req_ready, bus0.rsp_valid, mem_cs0, mem_web0);
        end
        next();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus0.req_ready, bus0.rsp_valid} !== {3'b001, 3'b000}) begin
            n_fail++; $display("FAIL mrr_first_grant got=%b/%b exp=001/000", bus0.req_ready, bus0.rsp_valid);
        end
        next();
        bus0.req_valid = 3'b000;
        for (int c = 4; c < 7; c++) begin
            @(negedge clk);
            n_checks++;
            if (c < 6 && bus0.rsp_valid !== 3'b000) begin
                n_fail++; $display("FAIL mrr_dropped c=%0d got=%b exp=000", c, bus0.rsp_valid);
            end else if (c == 6 && {bus0.rsp_valid, bus0.rsp_data} !== {3'b001, 16'h0000}) begin
                n_fail++; $display("FAIL mrr_post_reset_rsp got=%b/%h exp=001/0000", bus0.rsp_valid, bus0.rsp_data);
            end
            next();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        next();
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_write_then_read();
        test_watchdog();
        test_mid_read_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
